// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: dcache has priority, icache is guaranteed a grant after STARVE_LIMIT dcache wins.
// Latency: one IDLE arbitration cycle, then completion when the RAM reports ACCESS. Each requester stalls on its wait line.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_dstreak;
  logic [3:0] w_dstreak_nxt;
  logic       w_done;
  logic       w_dreq;

  assign w_done = (ramstate == RAM_ACCESS);
  assign w_dreq = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_dstreak <= '0;
    end else begin
      r_state   <= w_next;
      r_dstreak <= w_dstreak_nxt;
    end
  end

  // Streak counts dcache completions only while the icache is actually waiting.
  always_comb begin
    w_dstreak_nxt = r_dstreak;
    if (!iREN) begin
      w_dstreak_nxt = '0;
    end else if (r_state == IGNT && w_done) begin
      w_dstreak_nxt = '0;
    end else if (r_state == DGNT && w_done && r_dstreak != 4'hF) begin
      w_dstreak_nxt = r_dstreak + 4'd1;
    end
  end

  always_comb begin
    w_next   = r_state;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    dwait    = 1'b1;
    iwait    = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (iREN && r_dstreak == LIMIT) begin
          w_next = IGNT;
        end else if (w_dreq) begin
          w_next = DGNT;
        end else if (iREN) begin
          w_next = IGNT;
        end
      end
      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = ~w_done;
        if (w_done || !w_dreq) begin
          w_next = IDLE;
        end
      end
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = ~w_done;
        if (w_done || !iREN) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign dload = ramload;
  assign iload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written reset/starvation sequences, then random traffic vs a reference model.
module tb_mem_arbiter;

  localparam int LIM = 2;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: who owns the RAM (0 none, 1 dcache, 2 icache) and how many
  // dcache completions the waiting icache has sat through.
  int m_owner  = 0;
  int m_streak = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic dr, input logic dw, input logic ir,
                       input logic [31:0] da, input logic [31:0] ds, input logic [31:0] ia,
                       input logic [1:0] rs, input logic [31:0] rl);
    dREN = dr; dWEN = dw; iREN = ir;
    daddr = da; dstore = ds; iaddr = ia;
    ramstate = rs; ramload = rl;
  endtask

  task automatic check_model(input string tag);
    logic       e_ren, e_wen, e_dw, e_iw, done;
    logic [31:0] e_addr, e_st;
    done = (ramstate == 2'd2);
    e_ren = 0; e_wen = 0; e_dw = 1; e_iw = 1; e_addr = 0; e_st = 0;
    if (m_owner == 1) begin
      e_wen = dWEN; e_ren = dREN && !dWEN;
      e_addr = daddr; e_st = dstore; e_dw = !done;
    end else if (m_owner == 2) begin
      e_ren = iREN; e_addr = iaddr; e_iw = !done;
    end
    chk({tag, "_ctl"}, 128'({ramREN, ramWEN, dwait, iwait}), 128'({e_ren, e_wen, e_dw, e_iw}));
    chk({tag, "_dat"}, {ramaddr, ramstore, dload, iload}, {e_addr, e_st, ramload, ramload});
  endtask

  task automatic model_update();
    bit done, dreq;
    int ns;
    done = (ramstate == 2'd2);
    dreq = dREN || dWEN;
    ns = m_streak;
    if (!iREN) ns = 0;
    else if (m_owner == 2 && done) ns = 0;
    else if (m_owner == 1 && done && ns < 15) ns = ns + 1;
    case (m_owner)
      0: begin
        if (iREN && m_streak == LIM) m_owner = 2;
        else if (dreq) m_owner = 1;
        else if (iREN) m_owner = 2;
      end
      1: if (done || !dreq) m_owner = 0;
      default: if (done || !iREN) m_owner = 0;
    endcase
    m_streak = ns;
  endtask

  task automatic advance();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  typedef struct {
    logic        dr, dw, ir;
    logic [31:0] da, ds, ia;
    logic [1:0]  rs;
    logic [31:0] rl;
    logic [3:0]  e_ctl;   // {ramREN, ramWEN, dwait, iwait}
    logic [31:0] e_addr;
    logic [31:0] e_store;
  } vec_t;

  function automatic vec_t mk(input logic dr, input logic dw, input logic ir,
                              input logic [31:0] da, input logic [31:0] ds, input logic [31:0] ia,
                              input logic [1:0] rs, input logic [31:0] rl,
                              input logic [3:0] ec, input logic [31:0] ea, input logic [31:0] es);
    vec_t v;
    v.dr = dr; v.dw = dw; v.ir = ir; v.da = da; v.ds = ds; v.ia = ia;
    v.rs = rs; v.rl = rl; v.e_ctl = ec; v.e_addr = ea; v.e_store = es;
    return v;
  endfunction

  vec_t tbl[18];
  string ord;
  logic  pd, pw, pi;

  initial begin
    // Single dcache read, priority/lock with BUSY, withdrawn icache fetch, ERROR retry.
    tbl[0]  = mk(0,0,0, 32'h0,   32'h0,    32'h0,   2'd0, 32'h0,        4'b0011, 32'h0,   32'h0);
    tbl[1]  = mk(1,0,0, 32'h100, 32'h0,    32'h0,   2'd2, 32'hDEADBEEF, 4'b0011, 32'h0,   32'h0);
    tbl[2]  = mk(1,0,0, 32'h100, 32'h0,    32'h0,   2'd2, 32'hDEADBEEF, 4'b1001, 32'h100, 32'h0);
    tbl[3]  = mk(0,0,0, 32'h100, 32'h0,    32'h0,   2'd0, 32'h0,        4'b0011, 32'h0,   32'h0);
    tbl[4]  = mk(0,1,1, 32'h200, 32'h55,   32'h300, 2'd0, 32'h0,        4'b0011, 32'h0,   32'h0);
    tbl[5]  = mk(0,1,1, 32'h200, 32'h55,   32'h300, 2'd1, 32'h0,        4'b0111, 32'h200, 32'h55);
    tbl[6]  = mk(0,1,1, 32'h200, 32'h55,   32'h304, 2'd1, 32'h0,        4'b0111, 32'h200, 32'h55);
    tbl[7]  = mk(0,1,1, 32'h200, 32'h55,   32'h304, 2'd1, 32'h0,        4'b0111, 32'h200, 32'h55);
    tbl[8]  = mk(0,1,1, 32'h200, 32'h55,   32'h304, 2'd2, 32'h0,        4'b0101, 32'h200, 32'h55);
    tbl[9]  = mk(0,0,1, 32'h200, 32'h55,   32'h304, 2'd0, 32'h0,        4'b0011, 32'h0,   32'h0);
    tbl[10] = mk(0,0,1, 32'h200, 32'h55,   32'h304, 2'd1, 32'h0,        4'b1011, 32'h304, 32'h0);
    tbl[11] = mk(0,0,0, 32'h200, 32'h55,   32'h304, 2'd1, 32'h0,        4'b0011, 32'h304, 32'h0);
    tbl[12] = mk(0,0,0, 32'h200, 32'h55,   32'h304, 2'd0, 32'h0,        4'b0011, 32'h0,   32'h0);
    tbl[13] = mk(0,1,0, 32'h400, 32'h1234, 32'h0,   2'd3, 32'h0,        4'b0011, 32'h0,   32'h0);
    tbl[14] = mk(0,1,0, 32'h400, 32'h1234, 32'h0,   2'd3, 32'h0,        4'b0111, 32'h400, 32'h1234);
    tbl[15] = mk(0,1,0, 32'h400, 32'h1234, 32'h0,   2'd3, 32'h0,        4'b0111, 32'h400, 32'h1234);
    tbl[16] = mk(0,1,0, 32'h400, 32'h1234, 32'h0,   2'd2, 32'h0,        4'b0101, 32'h400, 32'h1234);
    tbl[17] = mk(0,0,0, 32'h400, 32'h1234, 32'h0,   2'd0, 32'h0,        4'b0011, 32'h0,   32'h0);

    nRST = 1'b0;
    drive(0,0,0, 0,0,0, 2'd0, 0);
    repeat (2) @(negedge CLK);
    #1;
    chk("reset_ctl", 128'({ramREN, ramWEN, dwait, iwait}), 128'(4'b0011));
    chk("reset_dat", 128'({ramaddr, ramstore}), 128'(0));
    @(negedge CLK);
    nRST = 1'b1;
    m_owner = 0; m_streak = 0;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].dr, tbl[i].dw, tbl[i].ir, tbl[i].da, tbl[i].ds, tbl[i].ia, tbl[i].rs, tbl[i].rl);
      #1;
      chk($sformatf("vec%0d_ctl", i), 128'({ramREN, ramWEN, dwait, iwait}), 128'(tbl[i].e_ctl));
      chk($sformatf("vec%0d_dat", i), 128'({ramaddr, ramstore, dload}),
          128'({tbl[i].e_addr, tbl[i].e_store, tbl[i].rl}));
      check_model($sformatf("vec%0d_model", i));
      advance();
    end

    // Asynchronous reset while the dcache holds a write grant.
    drive(0,1,0, 32'h500, 32'hABCD, 32'h0, 2'd1, 0);
    #1;
    advance();
    #1;
    chk("rstgnt_before", 128'({ramWEN, dwait, ramaddr}), 128'({1'b1, 1'b1, 32'h500}));
    nRST = 1'b0;
    #1;
    chk("rstgnt_async_ctl", 128'({ramREN, ramWEN, dwait, iwait}), 128'(4'b0011));
    chk("rstgnt_async_dat", 128'({ramaddr, ramstore}), 128'(0));
    m_owner = 0; m_streak = 0;
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    drive(0,0,0, 0,0,0, 2'd0, 0);
    #1;
    chk("rstgnt_after_ctl", 128'({ramREN, ramWEN, dwait, iwait}), 128'(4'b0011));
    check_model("rstgnt_after");
    advance();

    // Starvation guard: both requesters held, RAM completes at once.
    ord = "";
    for (int i = 0; i < 12; i++) begin
      drive(1,0,1, 32'h600 + i, 32'h0, 32'h700 + i, 2'd2, 32'(i));
      #1;
      check_model($sformatf("starve%0d", i));
      if (!dwait) ord = {ord, "D"};
      if (!iwait) ord = {ord, "I"};
      advance();
    end
    n_checks++;
    if (ord != "DDIDDI") begin
      n_err++;
      $display("FAIL starve_order: got %s expected DDIDDI", ord);
    end
    drive(0,0,0, 0,0,0, 2'd0, 0);
    #1;
    advance();

    // Random traffic: sticky requests with occasional toggles, random RAM status.
    pd = 0; pw = 0; pi = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) pd = ~pd;
      if ($urandom_range(0, 5) == 0) pw = ~pw;
      if ($urandom_range(0, 3) == 0) pi = ~pi;
      drive(pd, pw, pi, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), $urandom);
      #1;
      check_model($sformatf("rand%0d", i));
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
